pll_reset_sequencer: RTL and testbench

- Sits directly downstream of the rPLL wrapper. Clocked by the free-running 27 MHz crystal clock, which is the PLL input, so it never depends on the clock it supervises.
- Consumes the PLL LOCK output and drives the PLL RESET input.
- Produces the system reset for the PLL clock domains. That reset asserts only after lock is stable for a programmed time and drops again whenever lock is lost.
- Retries the PLL on lock timeout, keeps health status, and provides a free-running 1 us tick in the crystal domain.

---
 rtl/pll_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor in the crystal domain: drives PLL RESET, retries on
// lock timeout, and releases the PLL-domain system reset once lock is stable.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned TICK_DIV       = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_in,
  input  logic       clr_lost,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost,
  output logic       tick
);

  localparam int unsigned CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > PLL_RST_CYCLES) ? CNT_MAX_A : PLL_RST_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RETRY_W   = 4;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_PLLRST = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lock_s;
  logic                 pll_reset_d, sys_rst_n_d, ready_d, lock_lost_d;
  logic [RETRY_W-1:0]   retry_cnt_d;
  logic [TICK_W-1:0]    tick_cnt;

  // lock_in is asynchronous; only the last synchronizer stage is used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      cnt       <= '0;
      pll_reset <= 1'b0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pll_reset <= pll_reset_d;
      sys_rst_n <= sys_rst_n_d;
      ready     <= ready_d;
      retry_cnt <= retry_cnt_d;
      lock_lost <= lock_lost_d;
    end
  end

  // Next state and next registered outputs; cnt restarts on every state change
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pll_reset_d = 1'b0;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    retry_cnt_d = retry_cnt;
    lock_lost_d = lock_lost;

    case (state)
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_PLLRST: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = (state_d == S_PLLRST);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);

    if ((state != S_PLLRST) && (state_d == S_PLLRST) && (retry_cnt != {RETRY_W{1'b1}}))
      retry_cnt_d = retry_cnt + RETRY_W'(1);

    // A loss on the same cycle as a clear keeps the flag set
    if ((state == S_RUN) && (state_d == S_WAIT))
      lock_lost_d = 1'b1;
    else if (clr_lost)
      lock_lost_d = 1'b0;
  end

  // Free-running 1 us tick, independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
      tick     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock_in;
  logic       clr_lost;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;
  logic pll_seen = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .PLL_RST_CYCLES(4),
    .TICK_DIV      (27)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock_in  (lock_in),
    .clr_lost (clr_lost),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .retry_cnt(retry_cnt),
    .lock_lost(lock_lost),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pll_reset === 1'b1) pll_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_reset"}, 32'(pll_reset), 0);
    check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    check({tag, "_ready"},     32'(ready),     0);
    check({tag, "_retry_cnt"}, 32'(retry_cnt), 0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 0);
    check({tag, "_tick"},      32'(tick),      0);
  endtask

  initial begin
    rst_n    = 1'b0;
    lock_in  = 1'b0;
    clr_lost = 1'b0;
    step(3);
    check_reset_vals("rst");

    // 1: lock rises 5 cycles after release, RUN 11 edges later
    rst_n = 1'b1;
    step(5);
    lock_in = 1'b1;
    step(10);
    check("t1_sys_before", 32'(sys_rst_n), 0);
    step(1);
    check("t1_sys_rise", 32'(sys_rst_n), 1);
    check("t1_ready", 32'(ready), 1);
    check("t1_retry", 32'(retry_cnt), 0);

    // 4: loss in RUN, clear, then loss coinciding with clear
    lock_in = 1'b0;
    step(2);
    check("t4_sys_hold", 32'(sys_rst_n), 1);
    check("t4_ready_hold", 32'(ready), 1);
    step(1);
    check("t4_sys_fall", 32'(sys_rst_n), 0);
    check("t4_ready_fall", 32'(ready), 0);
    check("t4_lost_set", 32'(lock_lost), 1);
    clr_lost = 1'b1;
    step(1);
    clr_lost = 1'b0;
    check("t4_lost_clr", 32'(lock_lost), 0);
    lock_in = 1'b1;
    step(11);
    check("t4_rerun", 32'(sys_rst_n), 1);
    lock_in = 1'b0;
    step(2);
    clr_lost = 1'b1;
    step(1);
    clr_lost = 1'b0;
    check("t4_set_wins", 32'(lock_lost), 1);
    check("t4_sys_fall2", 32'(sys_rst_n), 0);

    // 3: one-cycle glitch at stable count 5, full count needed again
    lock_in = 1'b1;
    step(6);
    lock_in = 1'b0;
    step(1);
    lock_in = 1'b1;
    step(4);
    check("t3_no_run", 32'(sys_rst_n), 0);
    check("t3_no_ready", 32'(ready), 0);
    step(6);
    check("t3_sys_before", 32'(sys_rst_n), 0);
    step(1);
    check("t3_sys_rise", 32'(sys_rst_n), 1);
    check("t3_pll_never", 32'(pll_seen), 0);

    // 2: lock timeouts and retry saturation
    lock_in = 1'b0;
    rst_n   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(31);
    check("t2_pll_before", 32'(pll_reset), 0);
    step(1);
    check("t2_pll_on", 32'(pll_reset), 1);
    check("t2_retry1", 32'(retry_cnt), 1);
    step(3);
    check("t2_pll_last", 32'(pll_reset), 1);
    step(1);
    check("t2_pll_off", 32'(pll_reset), 0);
    check("t2_retry1_hold", 32'(retry_cnt), 1);
    step(464);
    check("t2_pll_14", 32'(pll_reset), 1);
    check("t2_retry14", 32'(retry_cnt), 14);
    step(36);
    check("t2_retry15", 32'(retry_cnt), 15);
    step(180);
    check("t2_pll_20", 32'(pll_reset), 1);
    check("t2_retry_sat", 32'(retry_cnt), 15);

    // 6: async reset in the middle of PLLRST
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6");
    step(2);
    rst_n = 1'b1;
    step(31);
    check("t6_pll_before", 32'(pll_reset), 0);
    step(1);
    check("t6_pll_on", 32'(pll_reset), 1);
    check("t6_retry1", 32'(retry_cnt), 1);

    // 5: tick pulses at every 27th edge while the FSM is busy
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      lock_in = (k >= 20 && k < 100) || (k >= 140 && k < 150);
      step(1);
      check($sformatf("t5_tick_%0d", k), 32'(tick), ((k % 27) == 0) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
